freq_meas_ctrl: RTL and testbench

Gated-window measurement controller for the frequency decoder datapath. It synchronizes an asynchronous pulse stream and opens a counting gate of programmable length. At gate close it latches the pulse count into a result register. The result is handed to the downstream consumer over a valid/ready handshake, in single-shot or continuous mode.

---
 rtl/freq_pkg.sv | 20 ++
 rtl/freq_pulse_sync_edge.sv | 28 ++
 rtl/freq_meas_ctrl.sv | 122 ++++++++++++
 tb/tb_freq_meas_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency measurement path.
package freq_pkg;

  localparam int FREQ_CNT_W  = 8;
  localparam int FREQ_GATE_W = 16;

  function automatic int unsigned cnt_max_of(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned CNT_MAX = cnt_max_of(FREQ_CNT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    HOLD = 2'd3
  } meas_state_e;

endpackage

// File: rtl/freq_pulse_sync_edge.sv
// Two-flop synchronizer for an asynchronous pulse pin plus a registered
// rising-edge strobe; the strobe appears 3 clk edges after the pin rises.
module pulse_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pulse_in,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      o_edge  <= 1'b0;
    end else begin
      r_sync1 <= i_pulse_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      o_edge  <= r_sync2 & ~r_prev;
    end
  end

endmodule

// File: rtl/freq_meas_ctrl.sv
// Gated-window pulse counter: counts synchronized rising edges over a
// programmable number of clk cycles and hands the result over valid/ready.
//
// state | meaning
// IDLE  | waiting for start
// ARM   | clear counter, load gate timer (1 cycle)
// GATE  | counting edges while timer runs down to 1
// HOLD  | result presented until valid & ready
module freq_meas_ctrl
  import freq_pkg::*;
#(
  parameter int CNT_W  = FREQ_CNT_W,
  parameter int GATE_W = FREQ_GATE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_continuous,
  input  logic              i_abort,
  input  logic [GATE_W-1:0] i_gate_cycles,
  input  logic              i_pulse_in,
  output logic              o_busy,
  output logic              o_count_valid,
  input  logic              i_count_ready,
  output logic [CNT_W-1:0]  o_count_data,
  output logic              o_overflow
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(cnt_max_of(CNT_W));

  meas_state_e       r_state;
  logic [GATE_W-1:0] r_timer;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sat;

  logic              w_edge;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_sat_nxt;
  logic [GATE_W-1:0] w_gate_load;

  pulse_sync_edge u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_pulse_in(i_pulse_in),
    .o_edge    (w_edge)
  );

  // Saturating increment; the next value is also what gets latched on the
  // last gate cycle so an edge landing there is still counted.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_edge && (r_cnt != LP_CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  assign w_sat_nxt   = r_sat | (w_cnt_nxt == LP_CNT_MAX);
  assign w_gate_load = (i_gate_cycles == '0) ? GATE_W'(1) : i_gate_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_cnt         <= '0;
      r_sat         <= 1'b0;
      o_busy        <= 1'b0;
      o_count_valid <= 1'b0;
      o_count_data  <= '0;
      o_overflow    <= 1'b0;
    end else if (i_abort) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_sat         <= 1'b0;
      o_busy        <= 1'b0;
      o_count_valid <= 1'b0;
      o_count_data  <= '0;
      o_overflow    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= ARM;
            o_busy  <= 1'b1;
          end
        end
        ARM: begin
          r_cnt   <= '0;
          r_sat   <= 1'b0;
          r_timer <= w_gate_load;
          r_state <= GATE;
        end
        GATE: begin
          r_cnt   <= w_cnt_nxt;
          r_sat   <= w_sat_nxt;
          r_timer <= r_timer - GATE_W'(1);
          if (r_timer == GATE_W'(1)) begin
            o_count_data  <= w_cnt_nxt;
            o_overflow    <= w_sat_nxt;
            o_count_valid <= 1'b1;
            r_state       <= HOLD;
          end
        end
        HOLD: begin
          if (o_count_valid && i_count_ready) begin
            o_count_valid <= 1'b0;
            if (i_continuous) begin
              r_state <= ARM;
            end else begin
              r_state <= IDLE;
              o_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Self-checking bench for freq_meas_ctrl: table vectors, randomized runs
// against a window-counting model, and hand sequences for stall/abort/reset.
module tb_freq_meas_ctrl;

  localparam int CNT_W  = 8;
  localparam int GATE_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic              i_continuous = 1'b0;
  logic              i_abort = 1'b0;
  logic [GATE_W-1:0] i_gate_cycles = '0;
  logic              i_pulse_in = 1'b0;
  logic              o_busy;
  logic              o_count_valid;
  logic              i_count_ready = 1'b0;
  logic [CNT_W-1:0]  o_count_data;
  logic              o_overflow;

  int checks = 0;
  int errors = 0;

  freq_meas_ctrl #(.CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_continuous (i_continuous),
    .i_abort      (i_abort),
    .i_gate_cycles(i_gate_cycles),
    .i_pulse_in   (i_pulse_in),
    .o_busy       (o_busy),
    .o_count_valid(o_count_valid),
    .i_count_ready(i_count_ready),
    .o_count_data (o_count_data),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    string nm;
    int    g;
    int    per;
    int    ofs;
    int    np;
    int    exp_cnt;
    int    exp_ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges reaching the counter at pin cycle (N-1)+r are counted iff
  // 0 <= r < G, where N is the start cycle and G = max(gate_cycles,1).
  function automatic void model(input int g, input int per, input int ofs, input int np,
                                output int cnt, output int ovf);
    int n;
    int gg;
    n  = 0;
    gg = (g == 0) ? 1 : g;
    for (int k = 0; k < np; k++) begin
      if ((ofs + k * per) >= 0 && (ofs + k * per) < gg) n++;
    end
    cnt = (n > 255) ? 255 : n;
    ovf = (n >= 255) ? 1 : 0;
  endfunction

  // Tick j is cycle t0+j; start is driven in j=2, pins at j = 1+ofs+k*per.
  task automatic run_meas(input string nm, input int g, input int per, input int ofs,
                          input int np, input int exp_cnt, input int exp_ovf);
    int gg;
    int last_j;
    int jend;
    int vj;
    int nvalid;
    int r;
    logic [CNT_W-1:0] d;
    logic ov;
    logic busy_arm;
    logic busy_after;
    gg     = (g == 0) ? 1 : g;
    last_j = 1 + ofs + (np - 1) * per;
    jend   = ((gg + 6) > (last_j + 3)) ? (gg + 6) : (last_j + 3);
    vj     = -1;
    nvalid = 0;
    d      = '0;
    ov     = 1'b0;
    busy_arm   = 1'b0;
    busy_after = 1'b1;
    i_continuous  = 1'b0;
    i_count_ready = 1'b1;
    i_gate_cycles = GATE_W'(g);
    for (int j = 0; j <= jend; j++) begin
      tick();
      if (o_count_valid) begin
        nvalid++;
        if (vj < 0) begin
          vj = j;
          d  = o_count_data;
          ov = o_overflow;
        end
      end
      if (j == 3) busy_arm = o_busy;
      if (j == gg + 5) busy_after = o_busy;
      i_start = (j == 2);
      if (j >= 4) i_gate_cycles = GATE_W'($urandom);
      r = j - 1 - ofs;
      i_pulse_in = (np > 0 && r >= 0 && (r % per) == 0 && (r / per) < np);
    end
    i_pulse_in = 1'b0;
    chk({nm, "_valid_cycle"}, vj, gg + 4);
    chk({nm, "_valid_width"}, nvalid, 1);
    chk({nm, "_data"}, d, exp_cnt);
    chk({nm, "_ovf"}, ov, exp_ovf);
    chk({nm, "_busy_arm"}, busy_arm, 1);
    chk({nm, "_busy_idle"}, busy_after, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int cnt;
    int ovf;
    int k;
    int bad;
    logic [CNT_W-1:0] held;

    vecs.push_back('{"single",    100,  7,  5,  10,  10, 0});
    vecs.push_back('{"first_last", 10,  9,  0,   2,   2, 0});
    vecs.push_back('{"one_after",  10, 10,  0,   2,   1, 0});
    vecs.push_back('{"one_before", 10,  2, -1,   2,   1, 0});
    vecs.push_back('{"saturate", 1000,  2,  0, 300, 255, 1});
    vecs.push_back('{"near_max",  600,  2,  0, 254, 254, 0});
    vecs.push_back('{"gate0_hit",   0,  2,  0,   1,   1, 0});
    vecs.push_back('{"gate0_miss",  0,  2, -1,   2,   0, 0});
    vecs.push_back('{"no_pulse",    3,  3,  0,   0,   0, 0});

    // reset state
    repeat (3) tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_count_valid, 0);
    chk("rst_data", o_count_data, 0);
    chk("rst_ovf", o_overflow, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    foreach (vecs[i]) begin
      run_meas(vecs[i].nm, vecs[i].g, vecs[i].per, vecs[i].ofs, vecs[i].np,
               vecs[i].exp_cnt, vecs[i].exp_ovf);
    end

    // continuous mode with a 50-cycle consumer stall
    i_continuous  = 1'b1;
    i_count_ready = 1'b0;
    i_gate_cycles = 16'd20;
    tick();
    i_start = 1'b1;
    k = 0;
    while (k < 40) begin
      tick();
      k++;
      i_start = 1'b0;
      i_pulse_in = (k == 2 || k == 5 || k == 8 || k == 11);
      if (o_count_valid) break;
    end
    chk("cont_first_valid_cycle", k, 22);
    chk("cont_first_data", o_count_data, 4);
    held = o_count_data;
    bad = 0;
    for (int s = 1; s <= 50; s++) begin
      tick();
      if (!o_count_valid || !o_busy || o_count_data !== held || o_overflow !== 1'b0) bad++;
      i_pulse_in = (s >= 5 && s <= 40 && (s % 4) == 0);
    end
    chk("stall_stable", bad, 0);
    i_count_ready = 1'b1;
    tick();
    i_count_ready = 1'b0;
    chk("cont_valid_drop", o_count_valid, 0);
    chk("cont_rearm_busy", o_busy, 1);
    k = 1;
    while (k < 40 && !o_count_valid) begin
      tick();
      k++;
    end
    chk("cont_second_valid_cycle", k, 22);
    chk("cont_second_data", o_count_data, 0);
    i_continuous  = 1'b0;
    i_count_ready = 1'b1;
    tick();
    chk("cont_end_valid", o_count_valid, 0);
    chk("cont_end_busy", o_busy, 0);
    repeat (2) tick();

    // abort in the 5th gate cycle
    run_meas("pre_abort", 12, 3, 0, 5, 4, 0);
    i_gate_cycles = 16'd50;
    i_count_ready = 1'b1;
    tick();
    i_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      i_start = 1'b0;
      i_pulse_in = (c % 2) == 1;
    end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_busy", o_busy, 0);
    chk("abort_valid", o_count_valid, 0);
    chk("abort_data", o_count_data, 0);
    bad = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      i_pulse_in = (c % 2) == 1;
      if (o_count_valid) bad++;
    end
    i_pulse_in = 1'b0;
    chk("abort_no_valid", bad, 0);
    repeat (3) tick();

    // asynchronous reset in the 5th gate cycle
    run_meas("pre_reset", 12, 3, 0, 3, 3, 0);
    i_gate_cycles = 16'd50;
    tick();
    i_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      i_start = 1'b0;
    end
    chk("prereset_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("areset_busy", o_busy, 0);
    chk("areset_data", o_count_data, 0);
    chk("areset_valid", o_count_valid, 0);
    chk("areset_ovf", o_overflow, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // randomized runs against the model
    for (int it = 0; it < 10; it++) begin
      int g, per, ofs, np;
      g   = (it == 9) ? int'($urandom_range(300, 400)) : int'($urandom_range(0, 40));
      per = (it == 9) ? 1 + 1 : int'($urandom_range(2, 5));
      ofs = int'($urandom_range(0, 12)) - 1;
      np  = (it == 9) ? int'($urandom_range(200, 180 + g / 2)) : int'($urandom_range(0, 30));
      model(g, per, ofs, np, cnt, ovf);
      run_meas($sformatf("rand%0d", it), g, per, ofs, np, cnt, ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
